// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional write-to-read bypass is selected by the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned NRD_DEF  = 2;
    localparam int unsigned NWR_DEF  = 1;

    // Address width that never collapses to zero for tiny files.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, clear at writeback.
// A reserve wins over a same-cycle clear of the same register; reset clears everything.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned NWR      = NWR_DEF,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = clog2_safe(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        // Set after clear so a new producer keeps the register busy.
        if (rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0))) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned NRD      = NRD_DEF,
    parameter int unsigned NWR      = NWR_DEF,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = clog2_safe(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREG-1:0]     busy_vec,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        // Later ports overwrite earlier ones: highest index wins.
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0))) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [AW-1:0] addr;
            addr                    = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = regs_q[addr];
            rd_busy[i]              = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    rd_busy[i]              = rsv_en && (rsv_addr == addr);
                end
            end
`endif
            if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_busy[i]              = 1'b0;
            end
        end
    end

    // Debug port sees architectural state only, never the bypass.
    assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp (NWR=2, NRD=2, XLEN=32, NREG=32, ZERO_REG=1).
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    localparam int unsigned KRd0 = 0, KRd1 = 1, KBusy0 = 2, KBusy1 = 3, KBvec = 4, KDbg = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NREG-1:0]     busy_vec;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    typedef struct {
        string       tag;
        int unsigned kind;
        logic [63:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_obs(input int unsigned kind);
        case (kind)
            KRd0:    return 64'(rd_data[0 +: XLEN]);
            KRd1:    return 64'(rd_data[XLEN +: XLEN]);
            KBusy0:  return 64'(rd_busy[0]);
            KBusy1:  return 64'(rd_busy[1]);
            KBvec:   return 64'(busy_vec);
            default: return 64'(dbg_data);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int unsigned kind, input logic [63:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    // Compare every pending expectation mid-cycle, away from the active edge.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, get_obs(e.kind), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic set_rd(input int unsigned p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic do_wr(input int unsigned p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[p]                = 1'b1;
        wr_addr[p*AW +: AW]     = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic do_rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        dbg_addr = '0;
        step();
        rst = 1'b0;

        for (int unsigned r = 0; r < NREG; r++) begin
            set_rd(0, AW'(r));
            set_rd(1, AW'(r));
            dbg_addr = AW'(r);
            expect_val($sformatf("rst_rd0_r%0d", r), KRd0, 64'h0);
            expect_val($sformatf("rst_rd1_r%0d", r), KRd1, 64'h0);
            expect_val($sformatf("rst_dbg_r%0d", r), KDbg, 64'h0);
            expect_val("rst_busy_vec", KBvec, 64'h0);
            sample();
            step();
        end

        // Write r5; same-cycle read shows old value unless bypassed.
        do_wr(0, 5, 32'hDEADBEEF);
        set_rd(0, 5);
        dbg_addr = 5;
        expect_val("wr5_same_cycle", KRd0, Byp ? 64'hDEADBEEF : 64'h0);
        expect_val("wr5_dbg_no_bypass", KDbg, 64'h0);
        sample();
        step();
        set_rd(1, 5);
        expect_val("wr5_rd1", KRd1, 64'hDEADBEEF);
        expect_val("wr5_dbg", KDbg, 64'hDEADBEEF);
        sample();
        step();

        // r0 ignores writes and reserves.
        do_wr(0, 0, 32'h1234);
        do_rsv(0);
        set_rd(0, 0);
        expect_val("r0_same_cycle", KRd0, 64'h0);
        expect_val("r0_busy_same", KBusy0, 64'h0);
        sample();
        step();
        expect_val("r0_read", KRd0, 64'h0);
        expect_val("r0_busy_vec", KBvec, 64'h0);
        sample();
        step();

        // Two ports write r7: port 1 wins.
        do_wr(0, 7, 32'h11);
        do_wr(1, 7, 32'h22);
        set_rd(1, 7);
        expect_val("conflict_same", KRd1, Byp ? 64'h22 : 64'h0);
        sample();
        step();
        dbg_addr = 7;
        expect_val("conflict_rd1", KRd1, 64'h22);
        expect_val("conflict_dbg", KDbg, 64'h22);
        sample();
        step();

        // Reserve r3.
        do_rsv(3);
        set_rd(0, 3);
        expect_val("rsv3_not_yet", KBusy0, 64'h0);
        sample();
        step();
        expect_val("rsv3_busy", KBusy0, 64'h1);
        expect_val("rsv3_vec", KBvec, 64'h8);
        sample();
        step();

        // Write and reserve r3 together: stays busy, data written.
        do_wr(0, 3, 32'h33);
        do_rsv(3);
        expect_val("wr_rsv3_same_busy", KBusy0, 64'h1);
        sample();
        step();
        expect_val("wr_rsv3_busy", KBusy0, 64'h1);
        expect_val("wr_rsv3_vec", KBvec, 64'h8);
        expect_val("wr_rsv3_data", KRd0, 64'h33);
        sample();
        step();

        // Write r3 alone: clears next cycle.
        do_wr(1, 3, 32'h44);
        expect_val("clr3_same_busy", KBusy0, Byp ? 64'h0 : 64'h1);
        expect_val("clr3_same_data", KRd0, Byp ? 64'h44 : 64'h33);
        expect_val("clr3_same_vec", KBvec, 64'h8);
        sample();
        step();
        expect_val("clr3_busy", KBusy0, 64'h0);
        expect_val("clr3_vec", KBvec, 64'h0);
        expect_val("clr3_data", KRd0, 64'h44);
        sample();
        step();

        // Bypass scenario on r9 with a pending reservation.
        do_rsv(9);
        step();
        do_wr(0, 9, 32'hCAFE);
        set_rd(1, 9);
        dbg_addr = 9;
        expect_val("byp9_data", KRd1, Byp ? 64'hCAFE : 64'h0);
        expect_val("byp9_busy", KBusy1, Byp ? 64'h0 : 64'h1);
        expect_val("byp9_dbg", KDbg, 64'h0);
        sample();
        step();
        do_wr(1, 9, 32'hBEEF);
        do_rsv(9);
        expect_val("byp9_rsv_data", KRd1, Byp ? 64'hBEEF : 64'hCAFE);
        expect_val("byp9_rsv_busy", KBusy1, Byp ? 64'h1 : 64'h0);
        sample();
        step();
        expect_val("byp9_after_busy", KBusy1, 64'h1);
        expect_val("byp9_after_data", KRd1, 64'hBEEF);
        expect_val("byp9_after_vec", KBvec, 64'h200);
        sample();
        step();

        // Reset while r4 is busy with 0xFF and a write is in flight.
        do_wr(0, 4, 32'hFF);
        do_rsv(4);
        step();
        set_rd(0, 4);
        expect_val("pre_rst_r4", KRd0, 64'hFF);
        expect_val("pre_rst_busy", KBusy0, 64'h1);
        sample();
        rst = 1'b1;
        do_wr(0, 4, 32'h77);
        do_rsv(4);
        step();
        rst      = 1'b0;
        dbg_addr = 4;
        set_rd(1, 7);
        expect_val("post_rst_r4", KRd0, 64'h0);
        expect_val("post_rst_busy", KBusy0, 64'h0);
        expect_val("post_rst_vec", KBvec, 64'h0);
        expect_val("post_rst_dbg", KDbg, 64'h0);
        expect_val("post_rst_r7", KRd1, 64'h0);
        sample();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read file in the decode stage.
- Generalised XLEN, register count, and number of read and write ports.
- Adds a per-register busy scoreboard (reserve at issue, clear at writeback) so the issue stage can stall on RAW hazards.
- Adds an optional write-to-read bypass.
- Sits between decode/issue (read, reserve) and writeback (write, clear).

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers (power of 2, >= 2); AW = $clog2(NREG).
- NRD, 2, number of combinational read ports.
- NWR, 1, number of write ports.
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reserves.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  scoreboard busy bit of each addressed register.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- rsv_en  in  1  reserve request from issue.
- rsv_addr  in  AW  destination register being reserved.
- busy_vec  out  NREG  full scoreboard, bit r = register r busy.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data; never bypassed.

Behaviour:
- Reset (rst=1 at posedge): all registers <= 0; busy_vec <= 0. Therefore rd_data=0, rd_busy=0, dbg_data=0 in the cycle after reset. Reset overrides any write or reserve in the same cycle. Reset mid-sequence discards pending reservations.
- Write: for each port w with wr_en[w]=1, the register at wr_addr[w] takes wr_data[w] at posedge. Register 0 is never written when ZERO_REG=1.
- Write conflict: if several enabled ports target the same address, the highest-indexed port wins. No error is flagged.
- Read: rd_data[i] = reg[rd_addr[i]] combinationally, zero latency. With ZERO_REG=1, address 0 always returns 0.
- Scoreboard set: rsv_en=1 sets busy[rsv_addr] at posedge. Ignored for address 0 when ZERO_REG=1.
- Scoreboard clear: any enabled write port clears busy[wr_addr] at posedge.
- Simultaneous reserve and write to the same register: busy stays 1 (new producer wins); the data is still written.
- Re-reserving a busy register: busy stays 1; there is no counting.
- rd_busy[i] = busy[rd_addr[i]], registered state only. A clear in the current cycle is not visible until the next cycle, except via bypass (see below).
- No internal state machine beyond the scoreboard.
- Storage is flops, not inferred RAM, because of multi-write and the full busy vector.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If an enabled write port targets rd_addr[i] this cycle, rd_data[i] returns that wr_data (highest index wins), and rd_busy[i] = 0 unless rsv_en targets the same address this cycle.
  - Address 0 with ZERO_REG=1 is still never bypassed.
  - Bypass is a combinational path from wr_* to rd_*.
- Undefined:
  - Reads return the pre-write value in the write cycle; the new value appears the next cycle.
  - rd_busy reflects registered state only.
- dbg_data is unaffected in both cases.

Decomposition:
- Shared package regfile_pkg: default XLEN/NREG constants, and a function clog2_safe returning 1 for NREG<=2.
- One natural sub-module, regfile_scoreboard: busy vector with set/clear priority and reset. It is instantiated once.
- Read muxes and bypass logic stay in the top module.

Test Plan:
- Reset then read all 32 registers on both ports -> every rd_data=0, busy_vec=0.
- Write 0xDEADBEEF to r5 via port 0; next cycle read r5 on port 1 -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
- NWR=2: both ports write r7 (0x11 on port 0, 0x22 on port 1) in the same cycle -> r7 = 0x22.
- Reserve r3 -> next cycle rd_busy for r3 = 1 and busy_vec[3] = 1. Write r3 together with rsv_en r3 -> busy stays 1. Write r3 alone -> busy clears the next cycle.
- With REGFILE_BYPASS_EN: write 0xCAFE to r9 while reading r9 in the same cycle -> rd_data = 0xCAFE, rd_busy = 0. Without the macro -> old value returned.
- Assert rst while r4 is busy and holds 0xFF, with wr_en active in the same cycle -> r4 = 0, busy_vec = 0, and the write is dropped.
